// File: rtl/rr_log_beat_packer.sv
// ---------------------------------------------------------------------------
// rr_log_beat_packer
//
// Packs byte-length-tagged log packets from the merge-tree root back-to-back,
// LSB-first with no gaps, into fixed OUT_W beats for the DRAM log writer.
// A flush drains whatever residue remains as a zero-padded final beat.
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RUN   | normal packing; full beats emitted, packets accepted
//   S_DRAIN | flushing residue; no packets accepted, last beat flagged
//   S_DONE  | one-cycle flush_done pulse, then back to S_RUN
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    packet handshake
//   in_data, in_len      packet bytes (byte 0 = bits [7:0]) and valid count
//   out_valid/out_ready  beat handshake
//   out_data, out_last   packed beat and final-beat-of-flush marker
//   flush_req            request to drain residue (sampled only in S_RUN)
//   flush_done           one-cycle pulse once the drain has completed
//   stat_bytes           bytes accepted since reset (wraps)
//   stat_beats           beats emitted since reset (wraps)
// ---------------------------------------------------------------------------
module rr_log_beat_packer #(
    parameter int IN_W  = 512,
    parameter int OUT_W = 512,
    parameter int CNT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    input  logic [$clog2(IN_W/8):0] in_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_last,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic [CNT_W-1:0]        stat_bytes,
    output logic [CNT_W-1:0]        stat_beats
);

    localparam int IN_BYTES  = IN_W / 8;
    localparam int OUT_BYTES = OUT_W / 8;
    localparam int LEN_W     = $clog2(IN_BYTES) + 1;
    localparam int BC_W      = $clog2(2 * OUT_BYTES);

    localparam logic [BC_W-1:0]  OUT_BYTES_C = BC_W'(OUT_BYTES);
    localparam logic [LEN_W-1:0] IN_BYTES_C  = LEN_W'(IN_BYTES);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*OUT_W-1:0]   r_buf;
    logic [BC_W-1:0]      r_cnt;
    logic [CNT_W-1:0]     r_stat_bytes;
    logic [CNT_W-1:0]     r_stat_beats;

    logic                 w_out_valid;
    logic                 w_out_last;
    logic                 w_in_ready;
    logic                 w_flush_done;
    logic                 w_pop;
    logic                 w_push;
    logic [LEN_W-1:0]     w_len;
    logic [IN_W-1:0]      w_in_masked;
    logic [2*OUT_W-1:0]   w_buf_pop;
    logic [2*OUT_W-1:0]   w_buf_ins;
    logic [2*OUT_W-1:0]   w_buf_nxt;
    logic [BC_W-1:0]      w_cnt_pop;
    logic [BC_W-1:0]      w_cnt_nxt;

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs. Outputs depend only on the
    // registered state/count, plus out_ready for in_ready.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_out_valid  = 1'b0;
        w_out_last   = 1'b0;
        w_in_ready   = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            S_RUN: begin
                w_out_valid = (r_cnt >= OUT_BYTES_C);
                // A beat leaving this cycle frees room for a full packet.
                w_in_ready  = (r_cnt < OUT_BYTES_C) | (w_out_valid & out_ready);
                if (flush_req) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_out_valid = (r_cnt != '0);
                w_out_last  = w_out_valid & (r_cnt <= OUT_BYTES_C);
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else if (w_out_last && out_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_flush_done = 1'b1;
                w_state_nxt  = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign w_pop  = w_out_valid & out_ready;
    assign w_push = in_valid & w_in_ready;

    // Oversized lengths saturate to a full packet.
    assign w_len = (in_len > IN_BYTES_C) ? IN_BYTES_C : in_len;

    // Bytes past the length are dropped so residue above cnt stays zero;
    // that is what makes the flush padding zero without extra logic.
    always_comb begin
        w_in_masked = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (LEN_W'(i) < w_len) begin
                w_in_masked[i*8 +: 8] = in_data[i*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: pop first, then insert the packet at the post-pop count.
    // ------------------------------------------------------------------
    always_comb begin
        w_buf_pop = r_buf;
        w_cnt_pop = r_cnt;
        if (w_pop) begin
            w_buf_pop = r_buf >> OUT_W;
            // The last flush beat may be partial; its residue is all padding.
            w_cnt_pop = w_out_last ? '0 : (r_cnt - OUT_BYTES_C);
        end
    end

    assign w_buf_ins = {{(2*OUT_W-IN_W){1'b0}}, w_in_masked} << {w_cnt_pop, 3'b000};

    always_comb begin
        w_buf_nxt = w_buf_pop;
        w_cnt_nxt = w_cnt_pop;
        if (w_push) begin
            w_buf_nxt = w_buf_pop | w_buf_ins;
            w_cnt_nxt = w_cnt_pop + BC_W'(w_len);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_stat_bytes <= '0;
            r_stat_beats <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_push) begin
                r_stat_bytes <= r_stat_bytes + CNT_W'(w_len);
            end
            if (w_pop) begin
                r_stat_beats <= r_stat_beats + 1'b1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_last   = w_out_last;
    assign out_data   = r_buf[OUT_W-1:0];
    assign flush_done = w_flush_done;
    assign stat_bytes = r_stat_bytes;
    assign stat_beats = r_stat_beats;

endmodule

// File: tb/tb_rr_log_beat_packer.sv
module tb_rr_log_beat_packer;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         flush_req = 1'b0;
    logic [511:0] in_data   = '0;
    logic [6:0]   in_len    = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_last;
    logic         flush_done;
    logic [511:0] out_data;
    logic [63:0]  stat_bytes;
    logic [63:0]  stat_beats;

    int n_chk  = 0;
    int n_fail = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    rr_log_beat_packer #(.IN_W(512), .OUT_W(512), .CNT_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .stat_bytes (stat_bytes),
        .stat_beats (stat_beats)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk512(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: a byte queue of everything accepted but not yet
    // emitted, plus the run/drain/done mode.
    // ---------------------------------------------------------------
    logic [7:0]   mq[$];
    int           m_mode = 0;   // 0 run, 1 drain, 2 done
    bit           m_ok   = 1'b0;
    logic [63:0]  m_bytes = '0;
    logic [63:0]  m_beats = '0;
    logic         e_ready, e_valid, e_last, e_done;
    logic [511:0] e_data;
    int           m_sz, m_take, m_len;

    always @(negedge clk) begin
        m_sz    = mq.size();
        e_ready = 1'b0;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_done  = 1'b0;
        case (m_mode)
            0: begin
                e_valid = (m_sz >= 64);
                e_ready = !e_valid || out_ready;
            end
            1: begin
                e_valid = (m_sz != 0);
                e_last  = e_valid && (m_sz <= 64);
            end
            default: e_done = 1'b1;
        endcase
        e_data = '0;
        for (int i = 0; i < 64 && i < m_sz; i++) e_data[i*8 +: 8] = mq[i];

        if (m_ok) begin
            chk1("in_ready", in_ready, e_ready);
            chk1("out_valid", out_valid, e_valid);
            chk1("out_last", out_last, e_last);
            chk1("flush_done", flush_done, e_done);
            chk64("stat_bytes", stat_bytes, m_bytes);
            chk64("stat_beats", stat_beats, m_beats);
            if (e_valid) chk512("out_data", out_data, e_data);
        end

        if (rst) begin
            mq.delete();
            m_mode  = 0;
            m_bytes = '0;
            m_beats = '0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            case (m_mode)
                0: if (flush_req) m_mode = 1;
                1: if (m_sz == 0 || (e_last && out_ready)) m_mode = 2;
                default: m_mode = 0;
            endcase
            if (e_valid && out_ready) begin
                m_take = (m_sz < 64) ? m_sz : 64;
                for (int i = 0; i < m_take; i++) void'(mq.pop_front());
                m_beats++;
            end
            if (in_valid && e_ready) begin
                m_len = (int'(in_len) > 64) ? 64 : int'(in_len);
                for (int i = 0; i < m_len; i++) mq.push_back(in_data[i*8 +: 8]);
                m_bytes += 64'(m_len);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers: inputs change only at posedge+1.
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // n bytes of base+i, garbage above so masking is exercised.
    function automatic logic [511:0] mkpkt(input int n, input int base);
        logic [511:0] r;
        r = rnd512();
        for (int i = 0; i < n; i++) r[i*8 +: 8] = 8'(base + i);
        return r;
    endfunction

    task automatic send(input int len, input logic [511:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_len   = 7'(len);
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 2000) begin
            tick();
            @(negedge clk);
            t++;
        end
        chk1("send_accepted", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        int t;
        t = 0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        while (!flush_done && t < 2000) begin
            tick();
            @(negedge clk);
            t++;
        end
        chk1("flush_done_seen", flush_done, 1'b1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [511:0] exp_beat;
    longint       sum_len;
    int           len;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk64("rst_stat_bytes", stat_bytes, 64'd0);
        tick();

        // 1: eight 8-byte packets form one beat with byte k = k
        out_ready = 1'b1;
        for (int p = 0; p < 8; p++) send(8, mkpkt(8, p*8));
        @(negedge clk);
        for (int k = 0; k < 64; k++) exp_beat[k*8 +: 8] = 8'(k);
        chk1("t1_valid", out_valid, 1'b1);
        chk512("t1_beat", out_data, exp_beat);
        tick();
        @(negedge clk);
        chk64("t1_beats", stat_beats, 64'd1);
        chk64("t1_bytes", stat_bytes, 64'd64);
        tick();

        // 2: 40 + 40 bytes, then flush the 16-byte residue
        send(40, mkpkt(40, 8'h01));
        send(40, mkpkt(40, 8'h80));
        @(negedge clk);
        for (int k = 0; k < 64; k++)
            exp_beat[k*8 +: 8] = (k < 40) ? 8'(k + 1) : 8'(8'h80 + k - 40);
        chk512("t2_beat0", out_data, exp_beat);
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        exp_beat = '0;
        for (int k = 0; k < 16; k++) exp_beat[k*8 +: 8] = 8'(8'h80 + 24 + k);
        chk1("t2_last_valid", out_valid, 1'b1);
        chk1("t2_last", out_last, 1'b1);
        chk512("t2_beat1", out_data, exp_beat);
        tick();
        @(negedge clk);
        chk1("t2_flush_done", flush_done, 1'b1);
        chk64("t2_beats", stat_beats, 64'd3);
        tick();
        @(negedge clk);
        chk1("t2_done_pulse", flush_done, 1'b0);
        tick();

        // 3: stall at cnt=100, then pop and push in the same cycle
        out_ready = 1'b0;
        send(50, mkpkt(50, 8'h10));
        send(50, mkpkt(50, 8'h60));
        for (int k = 0; k < 64; k++)
            exp_beat[k*8 +: 8] = (k < 50) ? 8'(8'h10 + k) : 8'(8'h60 + k - 50);
        @(negedge clk);
        chk1("t3_stall_ready", in_ready, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk1("t3_hold_valid", out_valid, 1'b1);
            chk512("t3_hold_data", out_data, exp_beat);
        end
        tick();
        out_ready = 1'b1;
        send(64, mkpkt(64, 8'hC0));
        @(negedge clk);
        for (int k = 0; k < 64; k++)
            exp_beat[k*8 +: 8] = (k < 36) ? 8'(8'h60 + 14 + k) : 8'(8'hC0 + k - 36);
        chk512("t3_beat_after", out_data, exp_beat);
        chk64("t3_bytes", stat_bytes, 64'd308);
        chk64("t3_beats", stat_beats, 64'd4);
        tick();
        do_flush();

        // 4: flush with empty residue
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk1("t4_drain_valid", out_valid, 1'b0);
        chk1("t4_drain_ready", in_ready, 1'b0);
        chk1("t4_drain_done", flush_done, 1'b0);
        tick();
        @(negedge clk);
        chk1("t4_done", flush_done, 1'b1);
        chk1("t4_done_ready", in_ready, 1'b0);
        tick();
        @(negedge clk);
        chk1("t4_run_done", flush_done, 1'b0);
        chk1("t4_run_ready", in_ready, 1'b1);
        tick();

        // 6: reset in the middle of a 70-byte drain
        out_ready = 1'b0;
        send(40, mkpkt(40, 8'h20));
        send(30, mkpkt(30, 8'h50));
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk1("t6_drain_valid", out_valid, 1'b1);
        chk1("t6_drain_last", out_last, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("t6_valid", out_valid, 1'b0);
        chk1("t6_ready", in_ready, 1'b1);
        chk64("t6_bytes", stat_bytes, 64'd0);
        chk64("t6_beats", stat_beats, 64'd0);
        chk1("t6_no_done", flush_done, 1'b0);
        tick();
        @(negedge clk);
        chk1("t6_no_done2", flush_done, 1'b0);
        tick();

        // 5: random lengths and back-pressure
        rand_ready = 1'b1;
        sum_len = 0;
        for (int p = 0; p < 10000; p++) begin
            if ($urandom_range(3) == 0) tick();
            len = $urandom_range(64);
            sum_len += len;
            send(len, rnd512());
            if ((p % 997) == 996) do_flush();
        end
        do_flush();
        rand_ready = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        chk1("t5_residue_empty", (mq.size() == 0), 1'b1);
        chk64("t5_stat_bytes", stat_bytes, 64'(sum_len));
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
